// File: rtl/z88_bus_sched.sv
// Z88 memory-bus phase scheduler: generates the 4-phase clkcnt sequence and
// time-multiplexes the single memory bus between screen fetch, CPU and DMA.
module z88_bus_sched #(
  parameter int unsigned STARVE = 8
) (
  input  logic        mck,
  input  logic        rin_n,
  input  logic        cke,
  input  logic        lcdon,
  output logic [1:0]  clkcnt,
  input  logic [21:0] va,
  output logic [7:0]  cdi,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [21:0] cpu_a,
  input  logic [7:0]  cpu_do,
  output logic        cpu_wait,
  output logic [7:0]  cpu_di,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [21:0] dma_a,
  input  logic [7:0]  dma_do,
  output logic        dma_ack,
  output logic [7:0]  dma_di,
  output logic [21:0] ma,
  output logic [7:0]  mdo,
  output logic        mwe,
  input  logic [7:0]  mdi
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE);

  logic [3:0] starve_cnt;
  logic       screen_slot;
  logic       forced;
  logic       cpu_own;
  logic       dma_own;

  // Slot type and bus owner for the current phase
  always_comb begin
    screen_slot = lcdon & ~clkcnt[1];
    forced      = dma_req & (starve_cnt == STARVE_LIM);
    cpu_own     = ~screen_slot & cpu_req & ~forced;
    dma_own     = ~screen_slot & dma_req & (forced | ~cpu_req);
  end

  // Bus drive and CPU wait; a forced DMA leaves the requesting CPU waiting
  always_comb begin
    ma       = cpu_a;
    mdo      = '0;
    mwe      = 1'b0;
    cpu_wait = cpu_req;
    cdi      = mdi;
    if (screen_slot) begin
      ma = va;
    end else if (cpu_own) begin
      mdo      = cpu_do;
      mwe      = cpu_we & cke;
      cpu_wait = ~cke;
    end else if (dma_own) begin
      ma  = dma_a;
      mdo = dma_do;
      mwe = dma_we & cke;
    end
  end

  // Phase counter, frozen while cke is low
  always_ff @(posedge mck or negedge rin_n) begin
    if (!rin_n) begin
      clkcnt <= '0;
    end else if (cke) begin
      clkcnt <= clkcnt + 2'd1;
    end
  end

  // Access completion: read-data latches and the one-cycle DMA acknowledge
  always_ff @(posedge mck or negedge rin_n) begin
    if (!rin_n) begin
      cpu_di  <= '0;
      dma_di  <= '0;
      dma_ack <= 1'b0;
    end else begin
      dma_ack <= cke & dma_own;
      if (cke && cpu_own && !cpu_we) cpu_di <= mdi;
      if (cke && dma_own && !dma_we) dma_di <= mdi;
    end
  end

  // DMA starvation counter, advanced only at the end of CPU slots
  always_ff @(posedge mck or negedge rin_n) begin
    if (!rin_n) begin
      starve_cnt <= '0;
    end else if (cke && !screen_slot) begin
      if (!dma_req || dma_own) begin
        starve_cnt <= '0;
      end else if (starve_cnt != STARVE_LIM) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
    end
  end

endmodule
